// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side driver for an external combinational 4-bit ALU.
// It accepts one command at a time and reads its operands from a small register file.
// It drives registered operands to the ALU, captures the ALU result, writes it back to
// the register file and returns a response over a valid/ready handshake.
//
// state  | meaning
// S_IDLE | ready for a command; operands and opcode latched on acceptance
// S_EXEC | ALU settling; result captured and written back at the end of this cycle
// S_RESP | response held until the consumer takes it
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_load,
  input  logic             cmd_use_imm,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [RAW-1:0]   cmd_rs1,
  input  logic [RAW-1:0]   cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_slt,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_slt,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [RAW-1:0]   r_rd;
  logic             r_load;
  logic [WIDTH-1:0] r_imm;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_slt;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic             w_illegal;

  // Opcodes 110 and 111 have no ALU meaning; r_alu_op always holds the latest non-load opcode
  assign w_illegal = (r_alu_op[2:1] == 2'b11);

  // Sequencer FSM, register file, ALU operand registers and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= 3'b000;
      r_rd         <= '0;
      r_load       <= 1'b0;
      r_imm        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_slt    <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_rd   <= cmd_rd;
            r_load <= cmd_load;
            r_imm  <= cmd_imm;
            // A load bypasses the ALU, so the ALU operands keep their previous values
            if (!cmd_load) begin
              r_alu_a  <= r_regs[cmd_rs1];
              r_alu_b  <= cmd_use_imm ? cmd_imm : r_regs[cmd_rs2];
              r_alu_op <= cmd_op;
            end
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_load) begin
            r_regs[r_rd] <= r_imm;
            r_rsp_result <= r_imm;
            r_rsp_slt    <= 1'b0;
            r_rsp_zero   <= (r_imm == '0);
            r_rsp_err    <= 1'b0;
          end else if (w_illegal) begin
            r_rsp_result <= '0;
            r_rsp_slt    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b1;
          end else begin
            r_regs[r_rd] <= alu_result;
            r_rsp_result <= alu_result;
            r_rsp_slt    <= alu_slt;
            r_rsp_zero   <= alu_zero;
            r_rsp_err    <= 1'b0;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_slt    = r_rsp_slt;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives the sequencer's ALU inputs.
// A register-file/response model predicts every response, and a per-cycle compare
// process checks the DUT outputs against that model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_use_imm;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_slt, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_slt, rsp_zero, rsp_err, busy;
  logic [3:0] rsp_result;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [3:0] m_regs [4];
  logic [3:0] exp_a, exp_b;
  logic [2:0] exp_op;
  logic [3:0] exp_res;
  logic       exp_slt, exp_zero, exp_err;

  alu_op_sequencer #(.WIDTH(4), .NREGS(4), .RAW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_load(cmd_load),
    .cmd_use_imm(cmd_use_imm), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_slt(alu_slt), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_slt(rsp_slt), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] f_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  // external combinational ALU
  always_comb begin
    alu_result = f_alu(alu_a, alu_b, alu_op);
    alu_slt    = (alu_op == 3'd5) && ($signed(alu_a) < $signed(alu_b));
    alu_zero   = (alu_result == 4'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_vs_ready", busy, !cmd_ready);
      check("alu_a", alu_a, exp_a);
      check("alu_b", alu_b, exp_b);
      check("alu_op", alu_op, exp_op);
      if (rsp_valid) begin
        check("rsp_result", rsp_result, exp_res);
        check("rsp_slt", rsp_slt, exp_slt);
        check("rsp_zero", rsp_zero, exp_zero);
        check("rsp_err", rsp_err, exp_err);
      end
    end
  end

  // Issue one command starting at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_cmd(input logic ld, input logic ui, input logic [2:0] op,
                        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [3:0] imm, input int hold,
                        output logic [3:0] o_res, output logic o_slt, output logic o_zero,
                        output logic o_err);
    logic [3:0] a, b, r;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_use_imm = ui; cmd_op = op;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    rsp_ready = (hold == 0);
    @(posedge clk);
    if (ld) begin
      exp_res = imm; exp_slt = 1'b0; exp_zero = (imm == 4'd0); exp_err = 1'b0;
      m_regs[rd] = imm;
    end else begin
      a = m_regs[rs1];
      b = ui ? imm : m_regs[rs2];
      exp_a = a; exp_b = b; exp_op = op;
      if (op >= 3'd6) begin
        exp_res = 4'd0; exp_slt = 1'b0; exp_zero = 1'b0; exp_err = 1'b1;
      end else begin
        r = f_alu(a, b, op);
        exp_res = r; exp_slt = (op == 3'd5) && (r == 4'd1); exp_zero = (r == 4'd0); exp_err = 1'b0;
        m_regs[rd] = r;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_load = 1'($urandom); cmd_use_imm = 1'($urandom);
    cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom); cmd_imm = 4'($urandom);
    check("lat_exec_valid", rsp_valid, 1'b0);
    check("lat_exec_ready", cmd_ready, 1'b0);
    @(negedge clk);
    check("lat_resp_valid", rsp_valid, 1'b1);
    o_res = rsp_result; o_slt = rsp_slt; o_zero = rsp_zero; o_err = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", rsp_valid, 1'b0);
    check("post_hs_ready", cmd_ready, 1'b1);
  endtask

  logic [3:0] res;
  logic       slt, zero, err;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_use_imm = 1'b0; cmd_op = 3'd0;
    cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 4'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    exp_a = 4'd0; exp_b = 4'd0; exp_op = 3'd0;
    exp_res = 4'd0; exp_slt = 1'b0; exp_zero = 1'b0; exp_err = 1'b0;
    #22;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_a", alu_a, 4'd0);
    check("rst_alu_b", alu_b, 4'd0);
    check("rst_alu_op", alu_op, 3'd0);
    check("rst_rsp_result", rsp_result, 4'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // 1: loads then ADD
    do_cmd(1, 0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5, 0, res, slt, zero, err);
    check("t1_load_res", res, 4'd5);
    do_cmd(1, 0, 3'd0, 2'd2, 2'd0, 2'd0, 4'd3, 0, res, slt, zero, err);
    do_cmd(0, 0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0, 0, res, slt, zero, err);
    check("t1_res", res, 4'd8);
    check("t1_slt", slt, 1'b0);
    check("t1_zero", zero, 1'b0);
    check("t1_alu_a", alu_a, 4'd5);
    check("t1_alu_b", alu_b, 4'd3);
    do_cmd(0, 1, 3'd3, 2'd3, 2'd0, 2'd0, 4'd0, 0, res, slt, zero, err);
    check("t1_reg0", res, 4'd8);

    // 2: SUB to zero, then 0 - 1 wraps
    do_cmd(0, 0, 3'd1, 2'd3, 2'd1, 2'd1, 4'd0, 0, res, slt, zero, err);
    check("t2_res", res, 4'd0);
    check("t2_zero", zero, 1'b1);
    do_cmd(0, 1, 3'd1, 2'd3, 2'd3, 2'd0, 4'd1, 0, res, slt, zero, err);
    check("t2_wrap", res, 4'hF);

    // 3: signed SLT
    do_cmd(1, 0, 3'd0, 2'd1, 2'd0, 2'd0, 4'b1001, 0, res, slt, zero, err);
    do_cmd(0, 1, 3'd5, 2'd3, 2'd1, 2'd0, 4'd2, 0, res, slt, zero, err);
    check("t3a_res", res, 4'd1);
    check("t3a_slt", slt, 1'b1);
    do_cmd(1, 0, 3'd0, 2'd1, 2'd0, 2'd0, 4'b1110, 0, res, slt, zero, err);
    do_cmd(0, 1, 3'd5, 2'd3, 2'd1, 2'd0, 4'b1010, 0, res, slt, zero, err);
    check("t3b_res", res, 4'd0);
    check("t3b_zero", zero, 1'b1);
    check("t3b_slt", slt, 1'b0);

    // 4: illegal opcode leaves r2 (=3) untouched
    do_cmd(0, 0, 3'd6, 2'd2, 2'd1, 2'd1, 4'd0, 0, res, slt, zero, err);
    check("t4_err", err, 1'b1);
    check("t4_res", res, 4'd0);
    check("t4_op", alu_op, 3'd6);
    do_cmd(0, 1, 3'd0, 2'd0, 2'd2, 2'd0, 4'd0, 0, res, slt, zero, err);
    check("t4_reg_kept", res, 4'd3);

    // 5: back-pressure
    do_cmd(0, 0, 3'd4, 2'd0, 2'd1, 2'd2, 4'd0, 5, res, slt, zero, err);
    check("t5_res", res, 4'b1101);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int hold;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_cmd(($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), hold, res, slt, zero, err);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 6: reset during EXEC
    do_cmd(1, 0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7, 0, res, slt, zero, err);
    do_cmd(1, 0, 3'd0, 2'd2, 2'd0, 2'd0, 4'd9, 0, res, slt, zero, err);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_use_imm = 1'b0; cmd_op = 3'd0;
    cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    exp_a = 4'd0; exp_b = 4'd0; exp_op = 3'd0;
    #1;
    check("t6_rsp_valid", rsp_valid, 1'b0);
    check("t6_alu_a", alu_a, 4'd0);
    check("t6_alu_b", alu_b, 4'd0);
    check("t6_alu_op", alu_op, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    check("t6_rsp_valid2", rsp_valid, 1'b0);
    do_cmd(0, 0, 3'd3, 2'd3, 2'd1, 2'd2, 4'd0, 0, res, slt, zero, err);
    check("t6_regs_cleared", res, 4'd0);
    do_cmd(0, 0, 3'd3, 2'd3, 2'd0, 2'd3, 4'd0, 0, res, slt, zero, err);
    check("t6_regs_cleared2", res, 4'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
